// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: eight requesters share one resource through a registered one-hot grant.
// Latency: request to grant is 1 cycle, release to deassert is 1 cycle, and every grant is followed by one idle gap cycle.
// Backpressure: a grant is held while its requester keeps req high, up to MAX_HOLD cycles (0 = no limit). en only gates new grants.
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   en          arbitration enable (blocks new grants only)
//   req[7:0]    request lines, one per requester
//   gnt[7:0]    registered one-hot grant (zero = no grant)
//   gnt_id[2:0] binary index of the current/last grant
//   gnt_valid   registered OR of gnt
//   timeout     one-cycle pulse when a grant is revoked by the hold limit
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = 8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;

  logic       win_vld;
  logic [2:0] win_id;
  logic [2:0] idx;

  // Scan from the highest offset down so the requester closest to ptr
  // (offset 0 first) is the last one written and therefore wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr_q;
    idx     = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr_q + 3'(i);
      if (req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hcnt_d      = hcnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
        if (en && win_vld) begin
          gnt_d       = 8'h01 << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          ptr_d       = win_id + 3'd1;  // winner drops to lowest priority
          hcnt_d      = 8'h00;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (!req[gnt_id_q]) begin
          // Release is checked first so it wins over a simultaneous expiry.
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (HOLD_EN && (hcnt_q == HOLD_LAST)) begin
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = IDLE;
        end else if (hcnt_q != 8'hFF) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      hcnt_q      <= 8'h00;
      gnt_q       <= 8'h00;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hcnt_q      <= hcnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with MAX_HOLD=4. Inputs change on the
// falling edge; outputs are checked on the falling edge.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // gnt must be one-hot or zero, and gnt_valid must track it, every cycle.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(gnt) || (gnt_valid !== (|gnt))) begin
      errors++;
      $display("FAIL onehot: gnt=%h gnt_valid=%b", gnt, gnt_valid);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 8'h00)    begin errors++; $display("FAIL reset_gnt: got %h want 00", gnt); end
    checks++; if (gnt_id !== 3'd0)  begin errors++; $display("FAIL reset_id: got %0d want 0", gnt_id); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", gnt_valid); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_to: got %b want 0", timeout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    en = 1'b1; req = 8'h04;
    @(negedge clk);
    checks++; if (gnt !== 8'h04)    begin errors++; $display("FAIL single_gnt: got %h want 04", gnt); end
    checks++; if (gnt_id !== 3'd2)  begin errors++; $display("FAIL single_id: got %0d want 2", gnt_id); end
    checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL single_vld: got %b want 1", gnt_valid); end
    req = 8'h00;
    @(negedge clk);
    checks++; if (gnt !== 8'h00)    begin errors++; $display("FAIL single_rel: got %h want 00", gnt); end
    checks++; if (gnt_id !== 3'd2)  begin errors++; $display("FAIL single_idhold: got %0d want 2", gnt_id); end
    // ptr is now 3: with requesters 1 and 3 pending, 3 must win.
    req = 8'h0A;
    @(negedge clk);
    checks++; if (gnt !== 8'h08)    begin errors++; $display("FAIL single_ptr: got %h want 08", gnt); end
    checks++; if (gnt_id !== 3'd3)  begin errors++; $display("FAIL single_ptrid: got %0d want 3", gnt_id); end
    req = 8'h00;
    @(negedge clk);
    checks++; if (gnt !== 8'h00)    begin errors++; $display("FAIL single_rel2: got %h want 00", gnt); end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_g [11] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                              8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01};
    logic       exp_t [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; req = 8'h81;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== exp_g[k]) begin errors++; $display("FAIL rot_gnt[%0d]: got %h want %h", k, gnt, exp_g[k]); end
      checks++;
      if (timeout !== exp_t[k]) begin errors++; $display("FAIL rot_to[%0d]: got %b want %b", k, timeout, exp_t[k]); end
    end
    req = 8'h00;
    @(negedge clk);
    checks++; if (gnt !== 8'h00)   begin errors++; $display("FAIL rot_rel: got %h want 00", gnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rot_relto: got %b want 0", timeout); end
  endtask

  task automatic test_wrap();
    req = 8'h40;
    @(negedge clk);
    checks++; if (gnt !== 8'h40)   begin errors++; $display("FAIL wrap_g6: got %h want 40", gnt); end
    req = 8'h00;
    @(negedge clk);
    req = 8'h03;
    @(negedge clk);
    checks++; if (gnt !== 8'h01)   begin errors++; $display("FAIL wrap_win: got %h want 01", gnt); end
    checks++; if (gnt_id !== 3'd0) begin errors++; $display("FAIL wrap_id: got %0d want 0", gnt_id); end
    req = 8'h00;
    @(negedge clk);
    // ptr is now 1: requesters 0 and 1 again, 1 must win.
    req = 8'h03;
    @(negedge clk);
    checks++; if (gnt !== 8'h02)   begin errors++; $display("FAIL wrap_ptr: got %h want 02", gnt); end
    req = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_enable();
    en = 1'b0; req = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 8'h00) begin errors++; $display("FAIL en_off[%0d]: got %h want 00", k, gnt); end
    end
    en = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL en_on: got %h want 04", gnt); end
    en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL en_hold: got %h want 04", gnt); end
    end
    req = 8'h00;
    @(negedge clk);
    checks++; if (gnt !== 8'h00)   begin errors++; $display("FAIL en_rel: got %h want 00", gnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL en_relto: got %b want 0", timeout); end
    req = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL en_gap: got %h want 00", gnt); end
    end
    req = 8'h00; en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_collision();
    // ptr is 3 here; drop req in the last allowed hold cycle.
    req = 8'h08;
    repeat (4) begin
      @(negedge clk);
      checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL col_hold: got %h want 08", gnt); end
    end
    req = 8'h00;
    @(negedge clk);
    checks++; if (gnt !== 8'h00)   begin errors++; $display("FAIL col_gnt: got %h want 00", gnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL col_to: got %b want 0", timeout); end
  endtask

  task automatic test_reset_mid();
    req = 8'h10;
    @(negedge clk);
    checks++; if (gnt !== 8'h10) begin errors++; $display("FAIL rm_pre: got %h want 10", gnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 8'h00)     begin errors++; $display("FAIL rm_async: got %h want 00", gnt); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL rm_vld: got %b want 0", gnt_valid); end
    @(negedge clk);
    // ptr restarts at 0, so requester 0 beats 4.
    req = 8'h11; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL rm_ptr0: got %h want 01", gnt); end
    req = 8'h00;
    @(negedge clk);
    req = 8'h10;
    @(negedge clk);
    checks++; if (gnt !== 8'h10)   begin errors++; $display("FAIL rm_gnt: got %h want 10", gnt); end
    checks++; if (gnt_id !== 3'd4) begin errors++; $display("FAIL rm_id: got %0d want 4", gnt_id); end
    req = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_enable();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
